// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and default constants for the instruction fetch
//            stage (state encoding, bus widths, reset PC, halt encoding).
//            HALT_WORD matters only when FETCH_HALT_DETECT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default widths of the instruction memory interface
  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DATA_W = 32;

  // PC value after reset
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  // Instruction encoding that stops fetching when halt detection is built in
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // Fetch controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Bundle of the fetch stage's memory port, redirect input and
//            IF/ID valid/ready handshake toward decode.
//            master = fetch stage side, slave = environment side
//            (instruction memory, branch unit, decode).
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  // Control
  logic              fetch_en;

  // Instruction memory read port
  logic [ADDR_W-1:0] inst_address;
  logic [DATA_W-1:0] inst_data;

  // Redirect from branch/jump resolution
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  // IF/ID handshake
  logic              id_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  // Status
  logic [31:0]       fetch_count;
  logic              halted;

  modport master (
    input  fetch_en,
    input  inst_data,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output inst_address,
    output if_valid,
    output if_instr,
    output if_pc,
    output fetch_count,
    output halted
  );

  modport slave (
    output fetch_en,
    output inst_data,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  inst_address,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  fetch_count,
    input  halted
  );

endinterface : instruction_fetch_if
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with valid/ready semantics.
//            flush clears valid, load captures a new word, and a handoff
//            without a new load empties the register. Otherwise it holds.
//            Data fields are retained on flush or handoff; only valid
//            qualifies them.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [DATA_W-1:0] d_instr,
  input  logic [ADDR_W-1:0] d_pc,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_instr,
  output logic [ADDR_W-1:0] q_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;

  // Output register: flush beats load, load beats drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_instr <= d_instr;
      r_pc    <= d_pc;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign q_valid = r_valid;
  assign q_instr = r_instr;
  assign q_pc    = r_pc;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage. Owns the PC and drives it as the word address of a
//            zero-latency instruction memory, captures the returned word in
//            the IF/ID register and hands it to decode with valid/ready.
//            Handles redirect (flush + new PC), stall and fetch enable.
//            Optional build macro: FETCH_HALT_DETECT_EN. When defined, a
//            loaded word equal to HALT_WORD parks the stage in HALTED until
//            a redirect or reset.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
`ifdef FETCH_HALT_DETECT_EN
  ,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEFAULT_HALT_WORD)
`endif
)(
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] C_PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_fetch_count;
  logic              r_halted;

  logic              w_if_valid;
  logic [DATA_W-1:0] w_if_instr;
  logic [ADDR_W-1:0] w_if_pc;
  logic              w_load;
  logic              w_handoff;
  logic              w_halt_hit;

  // A new word is captured only in FETCH, when the output slot is free or
  // draining this cycle, and never alongside a redirect (which flushes).
  assign w_load = (r_state == FETCH) && (!w_if_valid || bus.id_ready) &&
                  !bus.redirect_valid;

  // Decode takes the word; a simultaneous redirect discards it uncounted.
  assign w_handoff = w_if_valid && bus.id_ready && !bus.redirect_valid;

`ifdef FETCH_HALT_DETECT_EN
  assign w_halt_hit = w_load && (bus.inst_data == HALT_WORD);
`else
  // Without halt detection HALTED can never be entered, so halted stays 0.
  assign w_halt_hit = 1'b0;
`endif

  // Controller: state, PC, halted flag and handoff counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      if (w_handoff) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      if (bus.redirect_valid) begin
        // Redirect overrides everything, including HALTED
        r_pc     <= bus.redirect_pc;
        r_halted <= 1'b0;
        r_state  <= bus.fetch_en ? FETCH : IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.fetch_en) begin
              r_state <= FETCH;
            end
          end
          FETCH: begin
            if (w_halt_hit) begin
              // The halt word itself is delivered; PC stays on it
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end else begin
              if (w_load) begin
                r_pc <= r_pc + C_PC_STEP;
              end
              if (!bus.fetch_en) begin
                r_state <= IDLE;
              end
            end
          end
          HALTED: begin
            r_state <= HALTED;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .flush   (bus.redirect_valid),
    .ready   (bus.id_ready),
    .d_instr (bus.inst_data),
    .d_pc    (r_pc),
    .q_valid (w_if_valid),
    .q_instr (w_if_instr),
    .q_pc    (w_if_pc)
  );

  assign bus.inst_address = r_pc;
  assign bus.if_valid     = w_if_valid;
  assign bus.if_instr     = w_if_instr;
  assign bus.if_pc        = w_if_pc;
  assign bus.fetch_count  = r_fetch_count;
  assign bus.halted       = r_halted;

endmodule : instruction_fetch
`default_nettype wire
